// File: rtl/ad_spi_master_param.sv
// ad_spi_master_param
// On-demand SPI master for external ADC/DAC converters. A Start request
// latches one transmit word and the Read_En flag, then runs a single framed
// transfer. Word width, SCLK half-period, the CS-high gap between frames,
// the bit order and the SDI sample edge are all parameters. Every pin-facing
// output comes straight from a flop.
module ad_spi_master_param #(
    parameter int DATA_W      = 16,
    parameter int HALF_DIV    = 3,
    parameter int CS_GAP      = 10,
    parameter int LSB_FIRST   = 0,
    parameter int SAMPLE_FALL = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic              Read_En,
    input  logic [DATA_W-1:0] Data_Out,
    output logic [DATA_W-1:0] Data_In,
    output logic              Done,
    output logic              Busy,
    output logic              SCLK,
    output logic              CS,
    output logic              SDO,
    input  logic              SDI
);

    localparam int CNT_MAX = (HALF_DIV > CS_GAP) ? HALF_DIV : CS_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EDGE_W  = $clog2(2 * DATA_W);

    localparam bit LSB_MODE = (LSB_FIRST != 0);
    localparam bit FALL_SMP = (SAMPLE_FALL != 0);
    localparam bit HAS_GAP  = (CS_GAP > 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_DIV - 1);
    // The Done cycle and the final IDLE cycle are both CS-high, so the
    // GAP state itself covers the remaining CS_GAP-2 .. 0 count.
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'((CS_GAP > 1) ? (CS_GAP - 2) : 0);
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] FALL_LAST = EDGE_W'(2 * DATA_W - 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Bit currently presented on SDO for a given transmit shift register.
    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
        return LSB_MODE ? w[0] : w[DATA_W-1];
    endfunction

    // Moves the next transmit bit into the SDO position.
    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
        return LSB_MODE ? (w >> 1) : (w << 1);
    endfunction

    // Inserts one received bit so that the first bit lands at the word end
    // matching the configured bit order.
    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w,
                                                   input logic b);
        return LSB_MODE ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [EDGE_W-1:0]   edge_r, edge_s;
    logic [DATA_W-1:0]   tx_r, tx_s;
    logic [DATA_W-1:0]   rx_r, rx_s;
    logic                rd_en_r, rd_en_s;
    logic                sclk_r, sclk_s;
    logic                cs_r, cs_s;
    logic                sdo_r, sdo_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic [DATA_W-1:0]   data_in_r, data_in_s;
    logic                half_end_s;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        edge_s     = edge_r;
        tx_s       = tx_r;
        rx_s       = rx_r;
        rd_en_s    = rd_en_r;
        sclk_s     = sclk_r;
        cs_s       = cs_r;
        sdo_s      = sdo_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        data_in_s  = data_in_r;
        half_end_s = (cnt_r == HALF_LAST);

        case (state_r)
            ST_IDLE: begin
                sclk_s = 1'b0;
                cs_s   = 1'b1;
                sdo_s  = 1'b0;
                busy_s = 1'b0;
                if (Start) begin
                    state_s = ST_SETUP;
                    cnt_s   = '0;
                    edge_s  = '0;
                    tx_s    = Data_Out;
                    rx_s    = '0;
                    rd_en_s = Read_En;
                    cs_s    = 1'b0;
                    busy_s  = 1'b1;
                    sdo_s   = tx_bit(Data_Out);
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_SETUP: begin
                if (half_end_s) begin
                    // First SCLK rising edge.
                    state_s = ST_SHIFT;
                    cnt_s   = '0;
                    edge_s  = '0;
                    sclk_s  = 1'b1;
                    if (rd_en_r && !FALL_SMP) begin
                        rx_s = rx_shift(rx_r, SDI);
                    end else begin
                        rx_s = rx_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_SHIFT: begin
                if (half_end_s) begin
                    cnt_s = '0;
                    if (edge_r == EDGE_LAST) begin
                        state_s = ST_HOLD;
                        sclk_s  = 1'b0;
                    end else begin
                        edge_s = edge_r + EDGE_ONE;
                        sclk_s = ~sclk_r;
                        if (sclk_r) begin
                            // Falling edge: advance SDO except on the last one.
                            if (edge_r != FALL_LAST) begin
                                tx_s  = tx_shift(tx_r);
                                sdo_s = tx_bit(tx_shift(tx_r));
                            end else begin
                                tx_s  = tx_r;
                            end
                            if (rd_en_r && FALL_SMP) begin
                                rx_s = rx_shift(rx_r, SDI);
                            end else begin
                                rx_s = rx_r;
                            end
                        end else begin
                            // Rising edge.
                            if (rd_en_r && !FALL_SMP) begin
                                rx_s = rx_shift(rx_r, SDI);
                            end else begin
                                rx_s = rx_r;
                            end
                        end
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (half_end_s) begin
                    state_s = HAS_GAP ? ST_GAP : ST_IDLE;
                    cnt_s   = '0;
                    cs_s    = 1'b1;
                    sdo_s   = 1'b0;
                    done_s  = 1'b1;
                    busy_s  = HAS_GAP;
                    if (rd_en_r) begin
                        data_in_s = rx_r;
                    end else begin
                        data_in_s = data_in_r;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                sclk_s  = 1'b0;
                cs_s    = 1'b1;
                sdo_s   = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            edge_r    <= '0;
            tx_r      <= '0;
            rx_r      <= '0;
            rd_en_r   <= 1'b0;
            sclk_r    <= 1'b0;
            cs_r      <= 1'b1;
            sdo_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            data_in_r <= '0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            edge_r    <= edge_s;
            tx_r      <= tx_s;
            rx_r      <= rx_s;
            rd_en_r   <= rd_en_s;
            sclk_r    <= sclk_s;
            cs_r      <= cs_s;
            sdo_r     <= sdo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            data_in_r <= data_in_s;
        end
    end

    assign Data_In = data_in_r;
    assign Done    = done_r;
    assign Busy    = busy_r;
    assign SCLK    = sclk_r;
    assign CS      = cs_r;
    assign SDO     = sdo_r;

endmodule

// File: tb/tb_ad_spi_master_param.sv
// Testbench for ad_spi_master_param: three instances with different
// configurations, randomized words checked against a frame-level model
// (bit stream order, frame timing formula, CS gap, captured word).
`timescale 1ns/1ps
module tb_ad_spi_master_param;

    localparam int NDUT = 3;

    logic CLK;
    logic RST;
    logic [NDUT-1:0] start_w, rden_w, loop_w, sdi_drv;
    logic [15:0]     dout_w [NDUT];
    logic [15:0]     exp_din [NDUT];

    wire  [NDUT-1:0] sclk_w, cs_w, sdo_w, done_w, busy_w, sdi_w;
    wire  [15:0]     din0, din2;
    wire  [11:0]     din1;

    int n_cmp = 0;
    int n_bad = 0;

    // SDI is either the DUT's own SDO (loopback) or a device model bit.
    assign sdi_w = (loop_w & sdo_w) | (~loop_w & sdi_drv);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    ad_spi_master_param u_dut0 (
        .CLK(CLK), .RST(RST), .Start(start_w[0]), .Read_En(rden_w[0]),
        .Data_Out(dout_w[0]), .Data_In(din0), .Done(done_w[0]), .Busy(busy_w[0]),
        .SCLK(sclk_w[0]), .CS(cs_w[0]), .SDO(sdo_w[0]), .SDI(sdi_w[0]));

    ad_spi_master_param #(.DATA_W(12), .HALF_DIV(1), .CS_GAP(4), .LSB_FIRST(1), .SAMPLE_FALL(0)) u_dut1 (
        .CLK(CLK), .RST(RST), .Start(start_w[1]), .Read_En(rden_w[1]),
        .Data_Out(dout_w[1][11:0]), .Data_In(din1), .Done(done_w[1]), .Busy(busy_w[1]),
        .SCLK(sclk_w[1]), .CS(cs_w[1]), .SDO(sdo_w[1]), .SDI(sdi_w[1]));

    ad_spi_master_param #(.DATA_W(16), .HALF_DIV(2), .CS_GAP(3), .LSB_FIRST(0), .SAMPLE_FALL(1)) u_dut2 (
        .CLK(CLK), .RST(RST), .Start(start_w[2]), .Read_En(rden_w[2]),
        .Data_Out(dout_w[2]), .Data_In(din2), .Done(done_w[2]), .Busy(busy_w[2]),
        .SCLK(sclk_w[2]), .CS(cs_w[2]), .SDO(sdo_w[2]), .SDI(sdi_w[2]));

    function automatic int cfg_dw(input int s);
        case (s) 1: return 12; default: return 16; endcase
    endfunction
    function automatic int cfg_hd(input int s);
        case (s) 0: return 3; 1: return 1; default: return 2; endcase
    endfunction
    function automatic int cfg_gap(input int s);
        case (s) 0: return 10; 1: return 4; default: return 3; endcase
    endfunction
    function automatic logic cfg_lsb(input int s);
        return (s == 1);
    endfunction
    function automatic logic [15:0] get_din(input int s);
        case (s) 0: return din0; 1: return {4'h0, din1}; default: return din2; endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One requested frame on instance s, checked against the frame model.
    task automatic run_frame(input int s, input logic [15:0] data, input logic rd,
                             input logic loop, input logic pat_mode, input logic [15:0] pat);
        int dw, hd, exp_done, limit, rises, bad_phase, bad_sig, run, dones, done_at;
        logic [15:0] stream, exp_stream, mask, exp_d;
        logic prev_sclk, fb;
        dw = cfg_dw(s);
        hd = cfg_hd(s);
        exp_done = 1 + 2*hd + 2*dw*hd;
        limit = exp_done + cfg_gap(s) + 20;
        mask = (dw == 16) ? 16'hFFFF : ((16'h0001 << dw) - 16'h0001);
        exp_stream = 16'h0000;
        for (int j = 0; j < dw; j++) begin
            fb = cfg_lsb(s) ? data[j] : data[dw-1-j];
            exp_stream = {exp_stream[14:0], fb};
        end
        fb = cfg_lsb(s) ? data[0] : data[dw-1];
        exp_d = rd ? (loop ? (data & mask) : (pat & mask)) : exp_din[s];
        rises = 0; bad_phase = 0; bad_sig = 0; run = 0; dones = 0; done_at = -1;
        stream = 16'h0000; prev_sclk = 1'b0;

        @(negedge CLK);
        dout_w[s] = data; rden_w[s] = rd; loop_w[s] = loop;
        sdi_drv[s] = pat_mode ? 1'b0 : pat[0];
        start_w[s] = 1'b1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge CLK);
            if (k == 1) begin
                start_w[s] = 1'b0;
                dout_w[s]  = 16'($urandom);
                rden_w[s]  = ~rd;
                check_eq("first_cycle", {28'h0, cs_w[s], busy_w[s], sclk_w[s], sdo_w[s]},
                         {28'h0, 1'b0, 1'b1, 1'b0, fb});
            end
            if (k == 20) begin
                start_w[s] = 1'b1;
                dout_w[s]  = 16'($urandom);
            end
            if (k == 21) start_w[s] = 1'b0;
            if (sclk_w[s] && !prev_sclk) begin
                if (run != hd) bad_phase++;
                run = 1;
                rises++;
                stream = {stream[14:0], sdo_w[s]};
                if (pat_mode && rises <= 16) sdi_drv[s] = pat[16-rises];
            end else if (!sclk_w[s] && prev_sclk) begin
                if (run != hd) bad_phase++;
                run = 1;
            end else begin
                run++;
            end
            prev_sclk = sclk_w[s];
            if (done_w[s]) begin
                dones++;
                if (done_at < 0) begin
                    done_at = k;
                    check_eq("done_pins", {29'h0, cs_w[s], sdo_w[s], sclk_w[s]}, 32'h4);
                    check_eq("data_in", {16'h0, get_din(s)}, {16'h0, exp_d});
                end
            end
            if (done_at < 0 && (cs_w[s] !== 1'b0 || busy_w[s] !== 1'b1)) bad_sig++;
            if (done_at > 0 && busy_w[s] === 1'b0) break;
        end
        check_eq("done_cycle", done_at, exp_done);
        check_eq("done_count", dones, 1);
        check_eq("sclk_rises", rises, dw);
        check_eq("sclk_phase", bad_phase, 0);
        check_eq("frame_cs_busy", bad_sig, 0);
        check_eq("sdo_order", {16'h0, stream & mask}, {16'h0, exp_stream});
        check_eq("busy_release", {31'h0, busy_w[s]}, 32'h0);
        exp_din[s] = exp_d;
    endtask

    // Start held high: frames repeat with exactly CS_GAP CS-high cycles.
    task automatic back_to_back(input int s, input int n_frames);
        int dw, hd, period, span, gap_run, bad_gap, cs_falls, busy_rises, dones;
        logic prev_cs, prev_busy;
        dw = cfg_dw(s);
        hd = cfg_hd(s);
        period = 2*hd + 2*dw*hd + cfg_gap(s);
        span = n_frames * period - 1;
        gap_run = 0; bad_gap = 0; cs_falls = 0; busy_rises = 0; dones = 0;
        prev_cs = 1'b1; prev_busy = 1'b0;
        @(negedge CLK);
        rden_w[s] = 1'b0; loop_w[s] = 1'b1; start_w[s] = 1'b1;
        for (int k = 0; k < span + period + 10; k++) begin
            @(negedge CLK);
            if (k == span) start_w[s] = 1'b0;
            dout_w[s] = 16'($urandom);
            if (cs_w[s]) begin
                gap_run++;
            end else begin
                if (prev_cs) begin
                    cs_falls++;
                    if (cs_falls > 1 && gap_run != cfg_gap(s)) bad_gap++;
                end
                gap_run = 0;
            end
            if (busy_w[s] && !prev_busy) busy_rises++;
            if (done_w[s]) dones++;
            prev_cs = cs_w[s];
            prev_busy = busy_w[s];
        end
        check_eq("b2b_frames", cs_falls, span / period + 1);
        check_eq("b2b_gap", bad_gap, 0);
        check_eq("b2b_done_per_frame", dones, cs_falls);
        check_eq("b2b_busy_windows", busy_rises, cs_falls);
        check_eq("b2b_data_in_kept", {16'h0, get_din(s)}, {16'h0, exp_din[s]});
    endtask

    // Reset in the middle of a frame on instance 0.
    task automatic reset_mid();
        int dones;
        @(negedge CLK);
        dout_w[0] = 16'($urandom); rden_w[0] = 1'b1; loop_w[0] = 1'b1; start_w[0] = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge CLK);
            if (k == 1) start_w[0] = 1'b0;
        end
        RST = 1'b1;
        @(negedge CLK);
        check_eq("rst_mid_pins", {27'h0, cs_w[0], sclk_w[0], sdo_w[0], busy_w[0], done_w[0]}, 32'h10);
        check_eq("rst_mid_din", {16'h0, din0}, 32'h0);
        RST = 1'b0;
        for (int i = 0; i < NDUT; i++) exp_din[i] = 16'h0000;
        dones = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge CLK);
            if (done_w[0]) dones++;
        end
        check_eq("rst_mid_no_done", dones, 0);
    endtask

    initial begin
        RST = 1'b1;
        start_w = '0; rden_w = '0; loop_w = '1; sdi_drv = '0;
        for (int i = 0; i < NDUT; i++) begin
            dout_w[i]  = 16'h0000;
            exp_din[i] = 16'h0000;
        end
        repeat (3) @(negedge CLK);
        for (int s = 0; s < NDUT; s++) begin
            check_eq("reset_pins", {27'h0, sclk_w[s], cs_w[s], sdo_w[s], busy_w[s], done_w[s]}, 32'h8);
            check_eq("reset_din", {16'h0, get_din(s)}, 32'h0);
        end
        RST = 1'b0;

        run_frame(0, 16'hA5C3, 1'b1, 1'b1, 1'b0, 16'h0000);
        run_frame(0, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000);
        run_frame(0, 16'($urandom), 1'b0, 1'b0, 1'b0, 16'hFFFF);
        repeat (4) run_frame(0, 16'($urandom), 1'($urandom), 1'b1, 1'b0, 16'h0000);
        back_to_back(0, 3);

        run_frame(1, 16'h0801, 1'b1, 1'b1, 1'b0, 16'h0000);
        repeat (4) run_frame(1, 16'($urandom), 1'($urandom), 1'b1, 1'b0, 16'h0000);
        back_to_back(1, 4);

        run_frame(2, 16'($urandom), 1'b1, 1'b0, 1'b1, 16'h0F0F);
        repeat (3) run_frame(2, 16'($urandom), 1'b1, 1'b0, 1'b1, 16'($urandom));
        run_frame(2, 16'hC3A5, 1'b1, 1'b1, 1'b0, 16'h0000);

        reset_mid();
        run_frame(0, 16'($urandom), 1'b1, 1'b1, 1'b0, 16'h0000);
        run_frame(1, 16'($urandom), 1'b1, 1'b1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
